// File: rtl/sga_pkg.sv
// Shared encodings and defaults for the board RAM arbiter.
// Owner/state codes are also the db_owner debug values.
package sga_pkg;
    localparam int DEF_ADDR_W   = 6;
    localparam int DEF_DATA_W   = 6;
    localparam int DEF_MAX_HOLD = 16;

    localparam logic [1:0] OWN_IDLE = 2'd0;
    localparam logic [1:0] OWN_DISP = 2'd1;
    localparam logic [1:0] OWN_GAME = 2'd2;
    localparam logic [1:0] OWN_CHK  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = OWN_IDLE,
        ST_DISP = OWN_DISP,
        ST_GAME = OWN_GAME,
        ST_CHK  = OWN_CHK
    } state_t;
endpackage

// File: rtl/sga_rr_pick.sv
// Two-way round-robin picker between game and chk.
// The pointer moves to whichever of the two did not just give up the port.
module sga_rr_pick (
    input  logic clock,
    input  logic restart_n,
    input  logic game_req,
    input  logic chk_req,
    input  logic exit_valid,
    input  logic exit_game,
    output logic pick_game
);
    logic ptr_game;

    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) begin
            ptr_game <= 1'b1;
        end else if (exit_valid) begin
            ptr_game <= !exit_game;
        end
    end

    // A lone requester wins regardless of the pointer.
    assign pick_game = game_req && (!chk_req || ptr_game);
endmodule

// File: rtl/sga_ram_arbiter.sv
// Board RAM arbiter: disp has fixed priority, game/chk share round-robin,
// bursts are bounded by a hold counter unless game holds game_lock.
//
// state   | meaning
// IDLE    | nobody owns the RAM port
// DISP    | display scan owns the port
// GAME    | game move/write sequence owns the port
// CHK     | collision/apple checker owns the port
module sga_ram_arbiter
    import sga_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic              clock,
    input  logic              restart_n,
    input  logic              disp_req,
    input  logic              game_req,
    input  logic              chk_req,
    input  logic              disp_we,
    input  logic              game_we,
    input  logic              chk_we,
    input  logic [ADDR_W-1:0] disp_addr,
    input  logic [ADDR_W-1:0] game_addr,
    input  logic [ADDR_W-1:0] chk_addr,
    input  logic [DATA_W-1:0] disp_wdata,
    input  logic [DATA_W-1:0] game_wdata,
    input  logic [DATA_W-1:0] chk_wdata,
    input  logic              game_lock,
    output logic              disp_gnt,
    output logic              game_gnt,
    output logic              chk_gnt,
    output logic              disp_rvalid,
    output logic              game_rvalid,
    output logic              chk_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        db_owner
);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic               tag_valid;
    state_t             tag_owner;
    logic               owner_req, owner_we;
    logic [ADDR_W-1:0]  owner_addr;
    logic [DATA_W-1:0]  owner_wdata;
    logic               others_pending, hold_hit, leave, pick_game;

    sga_rr_pick u_rr_pick (
        .clock      (clock),
        .restart_n  (restart_n),
        .game_req   (game_req),
        .chk_req    (chk_req),
        .exit_valid (leave && (state == ST_GAME || state == ST_CHK)),
        .exit_game  (state == ST_GAME),
        .pick_game  (pick_game)
    );

    always_comb begin
        owner_req      = 1'b0;
        owner_we       = 1'b0;
        owner_addr     = '0;
        owner_wdata    = '0;
        others_pending = 1'b0;
        case (state)
            ST_DISP: begin
                owner_req = disp_req;  owner_we = disp_we;
                owner_addr = disp_addr; owner_wdata = disp_wdata;
                others_pending = game_req || chk_req;
            end
            ST_GAME: begin
                owner_req = game_req;  owner_we = game_we;
                owner_addr = game_addr; owner_wdata = game_wdata;
                others_pending = disp_req || chk_req;
            end
            ST_CHK: begin
                owner_req = chk_req;   owner_we = chk_we;
                owner_addr = chk_addr;  owner_wdata = chk_wdata;
                others_pending = disp_req || game_req;
            end
            default: ;
        endcase
    end

    // ">=" so a locked game burst, whose counter has saturated, is released
    // at the first edge after game_lock falls.
    assign hold_hit = (cnt >= CNT_W'(MAX_HOLD - 1)) && others_pending
                      && !(state == ST_GAME && game_lock);
    assign leave    = (state != ST_IDLE) && (!owner_req || hold_hit);

    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            tag_valid <= 1'b0;
            tag_owner <= ST_IDLE;
        end else begin
            state <= state_next;
            if (state_next != state || state_next == ST_IDLE) begin
                cnt <= '0;
            end else if (cnt != CNT_W'(MAX_HOLD)) begin
                cnt <= cnt + CNT_W'(1);
            end
            tag_valid <= owner_req && !owner_we;
            tag_owner <= state;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (disp_req)                 state_next = ST_DISP;
                else if (game_req || chk_req) state_next = pick_game ? ST_GAME : ST_CHK;
            end
            ST_DISP: begin
                if (leave) begin
                    if (game_req || chk_req) state_next = pick_game ? ST_GAME : ST_CHK;
                    else                     state_next = ST_IDLE;
                end
            end
            ST_GAME: begin
                if (leave) begin
                    if (disp_req)     state_next = ST_DISP;
                    else if (chk_req) state_next = ST_CHK;
                    else              state_next = ST_IDLE;
                end
            end
            ST_CHK: begin
                if (leave) begin
                    if (disp_req)      state_next = ST_DISP;
                    else if (game_req) state_next = ST_GAME;
                    else               state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        disp_gnt    = (state == ST_DISP);
        game_gnt    = (state == ST_GAME);
        chk_gnt     = (state == ST_CHK);
        ram_we      = owner_we && owner_req;
        ram_addr    = owner_addr;
        ram_wdata   = owner_wdata;
        db_owner    = state;
        disp_rvalid = tag_valid && (tag_owner == ST_DISP);
        game_rvalid = tag_valid && (tag_owner == ST_GAME);
        chk_rvalid  = tag_valid && (tag_owner == ST_CHK);
    end

    assign rdata = ram_rdata;
endmodule

// File: tb/tb_sga_ram_arbiter.sv
// Directed bench for the board RAM arbiter; expected values hand-derived.
module tb_sga_ram_arbiter;
    logic       clock = 1'b0;
    logic       restart_n;
    logic       disp_req, game_req, chk_req;
    logic       disp_we, game_we, chk_we;
    logic [5:0] disp_addr, game_addr, chk_addr;
    logic [5:0] disp_wdata, game_wdata, chk_wdata;
    logic       game_lock;
    logic       disp_gnt, game_gnt, chk_gnt;
    logic       disp_rvalid, game_rvalid, chk_rvalid;
    logic [5:0] rdata;
    logic       ram_we;
    logic [5:0] ram_addr, ram_wdata, ram_rdata;
    logic [1:0] db_owner;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    sga_ram_arbiter dut (
        .clock(clock), .restart_n(restart_n),
        .disp_req(disp_req), .game_req(game_req), .chk_req(chk_req),
        .disp_we(disp_we), .game_we(game_we), .chk_we(chk_we),
        .disp_addr(disp_addr), .game_addr(game_addr), .chk_addr(chk_addr),
        .disp_wdata(disp_wdata), .game_wdata(game_wdata), .chk_wdata(chk_wdata),
        .game_lock(game_lock),
        .disp_gnt(disp_gnt), .game_gnt(game_gnt), .chk_gnt(chk_gnt),
        .disp_rvalid(disp_rvalid), .game_rvalid(game_rvalid), .chk_rvalid(chk_rvalid),
        .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .db_owner(db_owner)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        disp_req = 0; game_req = 0; chk_req = 0;
        disp_we = 0; game_we = 0; chk_we = 0;
        disp_addr = 0; game_addr = 0; chk_addr = 0;
        disp_wdata = 0; game_wdata = 0; chk_wdata = 0;
        game_lock = 0; ram_rdata = 0;
    endtask

    task automatic do_reset();
        restart_n = 0;
        clear_inputs();
        step();
        restart_n = 1;
        #1;
    endtask

    initial begin
        restart_n = 1;
        clear_inputs();
        #2;
        // reset values and a single game write
        do_reset();
        check("rst_owner", 8'(db_owner), 8'd0);
        check("rst_gnts", 8'({disp_gnt, game_gnt, chk_gnt}), 8'd0);
        check("rst_we", 8'(ram_we), 8'd0);
        check("rst_addr", 8'(ram_addr), 8'd0);
        check("rst_rvalid", 8'({disp_rvalid, game_rvalid, chk_rvalid}), 8'd0);
        game_req = 1; game_we = 1; game_addr = 6'd5; game_wdata = 6'h2A;
        #1;
        check("game_gnt_lat0", 8'(game_gnt), 8'd0);
        step();
        check("game_gnt", 8'(game_gnt), 8'd1);
        check("game_we", 8'(ram_we), 8'd1);
        check("game_addr", 8'(ram_addr), 8'd5);
        check("game_wdata", 8'(ram_wdata), 8'h2A);
        check("game_owner", 8'(db_owner), 8'd2);
        game_req = 0;
        #1;
        check("drop_gnt_held", 8'(game_gnt), 8'd1);
        check("drop_no_we", 8'(ram_we), 8'd0);
        step();
        check("drop_idle", 8'(db_owner), 8'd0);
        check("idle_addr", 8'(ram_addr), 8'd0);

        // priority and direct handover
        do_reset();
        disp_req = 1; game_req = 1; chk_req = 1;
        step();
        check("all_disp", 8'(db_owner), 8'd1);
        disp_req = 0;
        step();
        check("hand_game", 8'(db_owner), 8'd2);
        game_req = 0;
        step();
        check("hand_chk", 8'(db_owner), 8'd3);
        chk_req = 0;
        step();
        check("hand_idle", 8'(db_owner), 8'd0);
        game_req = 1; chk_req = 1;
        step();
        check("rr_back_game", 8'(db_owner), 8'd2);
        game_req = 0;
        step();
        check("rr_then_chk", 8'(db_owner), 8'd3);
        chk_req = 0;
        step();
        check("rr_idle", 8'(db_owner), 8'd0);
        game_req = 1; chk_req = 1;
        step();
        check("rr_after_chk", 8'(db_owner), 8'd2);

        // tagged read return
        do_reset();
        chk_req = 1; chk_addr = 6'd12;
        step();
        check("rd_addr", 8'(ram_addr), 8'd12);
        check("rd_rv0", 8'(chk_rvalid), 8'd0);
        ram_rdata = 6'h11;
        step();
        check("rd_chk_rv", 8'(chk_rvalid), 8'd1);
        check("rd_data", 8'(rdata), 8'h11);
        check("rd_other_rv", 8'({disp_rvalid, game_rvalid}), 8'd0);
        chk_req = 0;
        step();
        check("rd_rv_end", 8'({disp_rvalid, game_rvalid, chk_rvalid}), 8'd0);

        // hold limit preempts disp
        do_reset();
        disp_req = 1; game_req = 1;
        step();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("hold_disp%0d", i), 8'(disp_gnt), 8'd1);
            step();
        end
        check("hold_disp_off", 8'(disp_gnt), 8'd0);
        check("hold_game_on", 8'(db_owner), 8'd2);
        check("hold_tag_disp", 8'({disp_rvalid, game_rvalid, chk_rvalid}), 8'b100);
        game_req = 0;
        step();
        check("hold_disp_back", 8'(db_owner), 8'd1);
        disp_req = 0;
        step();
        check("hold_idle", 8'(db_owner), 8'd0);

        // game_lock holds past the limit
        do_reset();
        game_req = 1; game_we = 1; game_lock = 1;
        step();
        disp_req = 1;
        for (int i = 0; i < 40; i++) begin
            check($sformatf("lock_game%0d", i), 8'(game_gnt), 8'd1);
            step();
        end
        game_lock = 0;
        #1;
        check("unlock_still", 8'(game_gnt), 8'd1);
        step();
        check("unlock_disp", 8'(db_owner), 8'd1);

        // reset mid burst
        do_reset();
        game_req = 1; game_we = 1; game_addr = 6'd7; game_wdata = 6'd3;
        step();
        check("mid_we", 8'(ram_we), 8'd1);
        restart_n = 0;
        #1;
        check("mid_gnt", 8'({disp_gnt, game_gnt, chk_gnt}), 8'd0);
        check("mid_we0", 8'(ram_we), 8'd0);
        check("mid_addr0", 8'(ram_addr), 8'd0);
        step();
        restart_n = 1;
        game_req = 0; game_we = 0;
        step();
        check("mid_rv", 8'({disp_rvalid, game_rvalid, chk_rvalid}), 8'd0);
        check("mid_idle", 8'(db_owner), 8'd0);
        game_req = 1; chk_req = 1;
        step();
        check("mid_rr_game", 8'(db_owner), 8'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sga_ram_arbiter.md
Name: sga_ram_arbiter

Overview:
- Shares the single-port board RAM (snake body/cell matrix) between three requesters:
  - display scan (disp),
  - game move/write sequence (game),
  - collision/apple checker (chk).
- Grants the RAM port in bursts: fixed priority for disp, round-robin between game and chk.
- Bounds hold time so the display cannot starve; muxes address, data and write enable onto the RAM.
- Returns tagged read-valid pulses to the requester that issued each read.

Parameters:
- ADDR_W, 6, RAM address width (64 cells).
- DATA_W, 6, RAM word width.
- MAX_HOLD, 16, cycles an owner may keep the port while another requester is pending.

Ports:
- clock  in  1  system clock, rising edge.
- restart_n  in  1  asynchronous, active-low reset.
- disp_req, game_req, chk_req  in  1 each  request the port; held for the whole burst.
- disp_we, game_we, chk_we  in  1 each  write enable per requester, valid while granted.
- disp_addr, game_addr, chk_addr  in  ADDR_W each  access address.
- disp_wdata, game_wdata, chk_wdata  in  DATA_W each  write data.
- game_lock  in  1  while high with game granted, the game burst is not preempted by the MAX_HOLD limit.
- disp_gnt, game_gnt, chk_gnt  out  1 each  port ownership (Moore, from state).
- disp_rvalid, game_rvalid, chk_rvalid  out  1 each  read data valid on rdata this cycle.
- rdata  out  DATA_W  RAM read data, forwarded to all requesters.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, 1-cycle synchronous latency.
- db_owner  out  2  debug: 0 idle, 1 disp, 2 game, 3 chk.

Behaviour:
- States: IDLE, DISP, GAME, CHK. State and db_owner carry the same encoding.
- Reset, asynchronous on restart_n low: state IDLE, rr pointer = game, hold counter 0, all gnt and rvalid 0, ram_we 0, ram_addr 0, ram_wdata 0.
- Reset mid-burst aborts immediately; no write occurs on the reset cycle.
- IDLE transitions, effective next edge:
  - disp_req → DISP.
  - Otherwise game_req and/or chk_req → the one selected by rr. If only one requests, it wins regardless of rr.
  - Otherwise stay in IDLE.
- Grant latency: 1 cycle from req to gnt when coming from IDLE.
- gnt_X = (state == X). It is asserted for the whole state, including the cycle after req drops.
- Access cycle = gnt_X && req_X.
  - ram_addr and ram_wdata take the owner's signals combinationally; they are 0 in IDLE.
  - ram_we = owner_we && owner_req, so a dropped request never writes.
- Read tracking: an access with we = 0 registers a 1-cycle tag. Next cycle the owner's rvalid = 1 and rdata = ram_rdata.
  - The tag survives a state change: a read on the last burst cycle still returns to its issuer.
- Hold counter: clears on entry to an owner state, increments each cycle in that state, saturates at MAX_HOLD.
- Leaving an owner state X happens at the edge when either condition holds:
  - req_X == 0; or
  - counter == MAX_HOLD−1, another requester is pending, and NOT (X == GAME && game_lock).
- Next state on leaving X: the highest-priority other pending requester (disp first, then rr between game and chk). Handover is direct with no IDLE bubble. If no one is pending → IDLE.
- If req_X is still high when preempted, X is re-queued and arbitrated normally later.
- rr pointer toggles to the other of game/chk whenever a GAME or CHK state is exited.
- Simultaneous requests in IDLE: disp > rr-selected of game/chk.
- game_lock is ignored when owner ≠ game. A locked game burst may exceed MAX_HOLD; the game FSM must bound its own burst length.

Decomposition:
- Shared package sga_pkg holds:
  - owner/state encoding constants: OWN_IDLE = 0, OWN_DISP = 1, OWN_GAME = 2, OWN_CHK = 3;
  - default ADDR_W, DATA_W, MAX_HOLD.
- One natural sub-module: sga_rr_pick, the two-way round-robin picker (pointer register, toggle, select). Everything else stays in the arbiter.

Test Plan:
- Reset then game_req alone, writing addr 5 data 0x2A → game_gnt at cycle 1; ram_we = 1, ram_addr = 5, ram_wdata = 0x2A the same cycle; db_owner = 2.
- All three req in IDLE → DISP first. Drop disp_req → direct handover to GAME (rr = game) with no IDLE cycle. Drop game_req → CHK. rr ends at game.
- chk reads addr 12 with ram_rdata = 0x11 → chk_rvalid = 1 exactly one cycle later, rdata = 0x11. Other rvalids stay 0, including when the read is the final burst cycle.
- disp holds req with game pending, MAX_HOLD = 16 → disp_gnt deasserts after 16 cycles, game_gnt next cycle. disp is re-granted after game releases.
- Game holds req with game_lock = 1 and disp pending for 40 cycles → game keeps the grant all 40 cycles. Lowering lock after the limit forces handover at the next edge.
- Pulse restart_n low mid game write burst → all gnt and ram_we drop immediately. No rvalid after release; state IDLE, rr = game.
